// File: rtl/matrix_stream_loader.sv
// Purpose : turns a flat 32-bit word stream (A then B, N*N words each) into indexed A/B write ports.
// Latency : one cycle from an accepted word to its write strobe; done pulses with the last B write.
// Backpress: s_ready is a pure state decode (high only in LOAD_A/LOAD_B); other words stay pending upstream.
//
// Ports:
//   clk, rst (synchronous, active-low)        : clock and reset
//   load_req                                  : starts a job, sampled only in IDLE
//   s_data/s_valid/s_ready/s_last             : input word stream, s_last marks word 2*N*N-1
//   a_in/a_i/a_j/a_we, b_in/b_i/b_j/b_we      : registered matrix element write ports
//   busy, done, err                           : job in progress, completion pulse, sticky framing error
//
// Build option: define MATRIX_LOADER_B_COLMAJOR_EN when B arrives column-major; b_i/b_j still
// carry the true row/column so the multiplier sees the same matrix either way.
module matrix_stream_loader #(
    parameter int N     = 10,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [31:0]      a_in,
    output logic [IDX_W-1:0] a_i,
    output logic [IDX_W-1:0] a_j,
    output logic             a_we,
    output logic [31:0]      b_in,
    output logic [IDX_W-1:0] b_i,
    output logic [IDX_W-1:0] b_j,
    output logic             b_we,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FLUSH} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             err_q, err_d;

    logic [31:0]      a_in_q, b_in_q;
    logic [IDX_W-1:0] a_i_q, a_j_q, b_i_q, b_j_q;
    logic             a_we_q, b_we_q;

    logic accept;
    logic at_end;
    logic final_word;
    logic row_fast;

    assign s_ready    = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept     = s_valid && s_ready;
    assign at_end     = (row_q == LAST) && (col_q == LAST);
    // Word index 2*N*N-1 is the last element of B, whatever order B arrives in.
    assign final_word = (state_q == LOAD_B) && at_end;

`ifdef MATRIX_LOADER_B_COLMAJOR_EN
    // Column-major B: row is the fast-moving counter while loading B.
    assign row_fast = (state_q == LOAD_B);
`else
    assign row_fast = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = LOAD_A;
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    // Framing is only flagged; the job still completes by count.
                    if (s_last != final_word) begin
                        err_d = 1'b1;
                    end
                    if (at_end) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : FLUSH;
                    end else if (row_fast) begin
                        if (row_q == LAST) begin
                            row_d = '0;
                            col_d = col_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        if (col_q == LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            a_in_q  <= '0;
            a_i_q   <= '0;
            a_j_q   <= '0;
            a_we_q  <= 1'b0;
            b_in_q  <= '0;
            b_i_q   <= '0;
            b_j_q   <= '0;
            b_we_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            a_we_q  <= accept && (state_q == LOAD_A);
            b_we_q  <= accept && (state_q == LOAD_B);
            // Data/index registers only move on a write so they hold between strobes.
            if (accept && (state_q == LOAD_A)) begin
                a_in_q <= s_data;
                a_i_q  <= row_q;
                a_j_q  <= col_q;
            end
            if (accept && (state_q == LOAD_B)) begin
                b_in_q <= s_data;
                b_i_q  <= row_q;
                b_j_q  <= col_q;
            end
        end
    end

    assign a_in = a_in_q;
    assign a_i  = a_i_q;
    assign a_j  = a_j_q;
    assign a_we = a_we_q;
    assign b_in = b_in_q;
    assign b_i  = b_i_q;
    assign b_j  = b_j_q;
    assign b_we = b_we_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == FLUSH);
    assign err  = err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
module tb_matrix_stream_loader;

    localparam int N     = 2;
    localparam int IDX_W = $clog2(N);

    logic             clk = 1'b0;
    logic             rst;
    logic             load_req;
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    logic [31:0]      a_in;
    logic [IDX_W-1:0] a_i;
    logic [IDX_W-1:0] a_j;
    logic             a_we;
    logic [31:0]      b_in;
    logic [IDX_W-1:0] b_i;
    logic [IDX_W-1:0] b_j;
    logic             b_we;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    matrix_stream_loader #(.N(N), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .a_in     (a_in),
        .a_i      (a_i),
        .a_j      (a_j),
        .a_we     (a_we),
        .b_in     (b_in),
        .b_i      (b_i),
        .b_j      (b_j),
        .b_we     (b_we),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a_in"},    a_in,    32'd0);
        chk({tag, " a_i"},     32'(a_i), 32'd0);
        chk({tag, " a_j"},     32'(a_j), 32'd0);
        chk({tag, " a_we"},    32'(a_we), 32'd0);
        chk({tag, " b_in"},    b_in,    32'd0);
        chk({tag, " b_i"},     32'(b_i), 32'd0);
        chk({tag, " b_j"},     32'(b_j), 32'd0);
        chk({tag, " b_we"},    32'(b_we), 32'd0);
        chk({tag, " s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, " busy"},    32'(busy), 32'd0);
        chk({tag, " done"},    32'(done), 32'd0);
        chk({tag, " err"},     32'(err), 32'd0);
    endtask

    // Hand layout for N=2: words 1..4 -> A(0,0),(0,1),(1,0),(1,1); words 5..8 -> B in stream order.
    task automatic exp_idx(input int w, output int i, output int j);
        int k;
        k = (w - 1) % 4;
`ifdef MATRIX_LOADER_B_COLMAJOR_EN
        if (w > 4) begin
            i = k % 2;
            j = k / 2;
        end else begin
            i = k / 2;
            j = k % 2;
        end
`else
        i = k / 2;
        j = k % 2;
`endif
    endtask

    // Start a job from IDLE: one cycle of load_req, then LOAD_A.
    task automatic start_job(input string tag);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk({tag, " busy after req"},  32'(busy), 32'd1);
        chk({tag, " s_ready in A"},    32'(s_ready), 32'd1);
        chk({tag, " no write yet"},    32'(a_we | b_we), 32'd0);
    endtask

    // Send words 1..stop_w; s_last on word last_pos (0 = never); optional idle gap after each word.
    task automatic send_words(input string tag, input int stop_w, input int last_pos, input bit gap);
        int i, j, bad_from;
        bit err_exp;
        bad_from = (last_pos == 0) ? 8 : last_pos;
        for (int w = 1; w <= stop_w; w++) begin
            s_valid = 1'b1;
            s_data  = 32'(w);
            s_last  = (w == last_pos);
            chk($sformatf("%s w%0d ready", tag, w), 32'(s_ready), 32'd1);
            step();
            s_valid = 1'b0;
            s_last  = 1'b0;
            exp_idx(w, i, j);
            if (w <= 4) begin
                chk($sformatf("%s w%0d a_we", tag, w), 32'(a_we), 32'd1);
                chk($sformatf("%s w%0d b_we", tag, w), 32'(b_we), 32'd0);
                chk($sformatf("%s w%0d a_in", tag, w), a_in, 32'(w));
                chk($sformatf("%s w%0d a_i", tag, w), 32'(a_i), 32'(i));
                chk($sformatf("%s w%0d a_j", tag, w), 32'(a_j), 32'(j));
            end else begin
                chk($sformatf("%s w%0d b_we", tag, w), 32'(b_we), 32'd1);
                chk($sformatf("%s w%0d a_we", tag, w), 32'(a_we), 32'd0);
                chk($sformatf("%s w%0d b_in", tag, w), b_in, 32'(w));
                chk($sformatf("%s w%0d b_i", tag, w), 32'(b_i), 32'(i));
                chk($sformatf("%s w%0d b_j", tag, w), 32'(b_j), 32'(j));
                chk($sformatf("%s w%0d a_in hold", tag, w), a_in, 32'd4);
            end
            chk($sformatf("%s w%0d done", tag, w), 32'(done), (w == 8) ? 32'd1 : 32'd0);
            err_exp = (last_pos != 8) && (w >= bad_from);
            chk($sformatf("%s w%0d err", tag, w), 32'(err), 32'(err_exp));
            if (gap && w < stop_w) begin
                step();
                chk($sformatf("%s gap%0d no we", tag, w), 32'(a_we | b_we), 32'd0);
                chk($sformatf("%s gap%0d done", tag, w), 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        load_req = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;

        // Reset held two cycles.
        step();
        step();
        rst = 1'b1;
        chk_all_zero("reset");

        // Words offered in IDLE must not be taken.
        s_valid = 1'b1;
        s_data  = 32'd99;
        step();
        chk("idle ready", 32'(s_ready), 32'd0);
        chk("idle no we", 32'(a_we | b_we), 32'd0);
        chk("idle busy",  32'(busy), 32'd0);
        s_valid = 1'b0;

        // Back-to-back job; load_req held through FLUSH is not taken there.
        start_job("b2b");
        send_words("b2b", 8, 8, 1'b0);
        load_req = 1'b1;
        step();
        chk("b2b idle after flush", 32'(busy), 32'd0);
        chk("b2b done cleared",     32'(done), 32'd0);
        chk("b2b last b_in hold",   b_in, 32'd8);
        chk("b2b err",              32'(err), 32'd0);

        // load_req still high in IDLE starts the gapped job.
        step();
        load_req = 1'b0;
        chk("gap busy", 32'(busy), 32'd1);
        send_words("gap", 8, 8, 1'b1);
        step();
        chk("gap idle", 32'(busy), 32'd0);

        // Early s_last on word 3, missing on word 8.
        start_job("frm");
        send_words("frm", 8, 3, 1'b0);
        step();
        chk("frm err sticky", 32'(err), 32'd1);
        chk("frm idle",       32'(busy), 32'd0);
        start_job("clr");
        chk("clr err cleared", 32'(err), 32'd0);
        send_words("clr", 8, 8, 1'b0);
        step();

        // Reset in the middle of B.
        start_job("mid");
        send_words("mid", 5, 8, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_all_zero("midrst");
        start_job("post");
        send_words("post", 8, 8, 1'b0);
        step();
        chk("post idle", 32'(busy), 32'd0);
        chk("post err",  32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
